// File: rtl/disco_rigido_setorizado_if.sv
// Request/burst bus between a host (CPU/IO controller) and the sectored disk model.
// master drives requests and write data; slave returns handshake, read data and status.
interface disco_rigido_setorizado_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] wdata;
  logic              wready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output req, we, addr, len, wdata,
    input  wready, rdata, rvalid, busy, done, err
  );

  modport slave (
    input  req, we, addr, len, wdata,
    output wready, rdata, rvalid, busy, done, err
  );
endinterface

// File: rtl/disco_rigido_setorizado.sv
// Sector-organised disk model: request/done handshake, bursts, range check, seek latency.
// Optional DISK_WRITE_PROTECT_EN adds a wp input that rejects write bursts.
module disco_rigido_setorizado #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int DISK_SIZE    = 1024,
  parameter int SECTOR_WORDS = 64,
  parameter int SEEK_CYCLES  = 4,
  parameter int LEN_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  disco_rigido_setorizado_if.slave  bus,
  output logic [ADDR_W-1:0]         head_sector
`ifdef DISK_WRITE_PROTECT_EN
  ,
  input  logic                      wp
`endif
);

  localparam int SHIFT  = $clog2(SECTOR_WORDS);
  localparam int IDX_W  = (DISK_SIZE > 1) ? $clog2(DISK_SIZE) : 1;
  localparam int SEEK_W = $clog2(SEEK_CYCLES + 1);
  localparam logic [SEEK_W-1:0] SEEK_LAST = SEEK_W'(SEEK_CYCLES - 1);
  localparam logic [ADDR_W:0]   DISK_END  = (ADDR_W + 1)'(DISK_SIZE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SEEK  = 3'd2,
    XFER  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic                we_r;
  logic [ADDR_W-1:0]   cur_r;
  logic [LEN_W-1:0]    cnt_r;
  logic [SEEK_W-1:0]   seek_cnt_r;
  logic [ADDR_W-1:0]   head_r;
  logic                busy_r;
  logic                wready_r;
  logic                rvalid_r;
  logic                done_r;
  logic                err_r;
  logic [DATA_W-1:0]   rdata_r;

  logic [DATA_W-1:0]   mem [0:DISK_SIZE-1];

  logic [ADDR_W:0]     span_end_s;
  logic                out_of_range_s;
  logic [ADDR_W-1:0]   cur_sector_s;
  logic [ADDR_W-1:0]   nxt_cur_s;
  logic                crossing_s;
  logic                wp_reject_s;
  logic [IDX_W-1:0]    mem_idx_s;

  // Range, sector and protection decode from the latched request state
  always_comb begin
    span_end_s     = {1'b0, cur_r} + (ADDR_W + 1)'(cnt_r);
    out_of_range_s = (span_end_s > DISK_END);
    cur_sector_s   = cur_r >> SHIFT;
    nxt_cur_s      = cur_r + ADDR_W'(1);
    crossing_s     = ((nxt_cur_s >> SHIFT) != cur_sector_s);
    mem_idx_s      = cur_r[IDX_W-1:0];
`ifdef DISK_WRITE_PROTECT_EN
    wp_reject_s    = we_r & wp;
`else
    wp_reject_s    = 1'b0;
`endif
  end

  // Storage array: written only while wready is asserted, never cleared by reset
  always_ff @(posedge clk) begin
    if (wready_r) begin
      mem[mem_idx_s] <= bus.wdata;
    end
  end

  // Request FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      cur_r      <= '0;
      cnt_r      <= '0;
      seek_cnt_r <= '0;
      head_r     <= '0;
      busy_r     <= 1'b0;
      wready_r   <= 1'b0;
      rvalid_r   <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      rdata_r    <= '0;
    end else begin
      // Pulsed outputs fall back to zero unless re-asserted below
      rvalid_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req) begin
            we_r    <= bus.we;
            cur_r   <= bus.addr;
            cnt_r   <= (bus.len == '0) ? LEN_W'(1) : bus.len;
            busy_r  <= 1'b1;
            state_r <= CHECK;
          end
        end
        CHECK: begin
          if (out_of_range_s || wp_reject_s) begin
            done_r  <= 1'b1;
            err_r   <= 1'b1;
            state_r <= DONE;
          end else if (cur_sector_s != head_r) begin
            seek_cnt_r <= SEEK_LAST;
            state_r    <= SEEK;
          end else begin
            wready_r <= we_r;
            state_r  <= XFER;
          end
        end
        SEEK: begin
          if (seek_cnt_r == '0) begin
            head_r   <= cur_sector_s;
            wready_r <= we_r;
            state_r  <= XFER;
          end else begin
            seek_cnt_r <= seek_cnt_r - SEEK_W'(1);
          end
        end
        XFER: begin
          if (!we_r) begin
            rdata_r  <= mem[mem_idx_s];
            rvalid_r <= 1'b1;
          end
          cur_r <= nxt_cur_s;
          cnt_r <= cnt_r - LEN_W'(1);
          if (cnt_r == LEN_W'(1)) begin
            wready_r <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else if (crossing_s) begin
            // Next word lives in another sector: the head has to move first
            wready_r   <= 1'b0;
            seek_cnt_r <= SEEK_LAST;
            state_r    <= SEEK;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r   <= 1'b0;
          wready_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.wready  = wready_r;
  assign bus.rdata   = rdata_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign head_sector = head_r;

endmodule

// File: tb/tb_disco_rigido_setorizado.sv
// Directed table-driven bench for disco_rigido_setorizado (default parameters).
module tb_disco_rigido_setorizado;

  logic        clk;
  logic        rst_n;
  logic [31:0] head_sector;
`ifdef DISK_WRITE_PROTECT_EN
  logic        wp;
`endif

  disco_rigido_setorizado_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(8)) bus ();

  disco_rigido_setorizado dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .head_sector (head_sector)
`ifdef DISK_WRITE_PROTECT_EN
    ,
    .wp          (wp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] base;
    int          exp_done;
    logic        exp_err;
    int          exp_beats;
    int          exp_first;
    int          exp_cyc2;
    logic [31:0] exp_head;
    logic        chk_data;
  } vec_t;

  vec_t        vecs [11];
  int          checks;
  int          errors;
  int          nbeats;
  int          done_cyc;
  logic        err_seen;
  int          beat_cyc [16];
  logic [31:0] beat_dat [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Issue one request; k counts cycles after the accepting edge T0, sampled mid-cycle
  task automatic run_txn(input logic twe, input logic [31:0] taddr,
                         input logic [7:0] tlen, input logic [31:0] tbase);
    nbeats   = 0;
    done_cyc = -1;
    err_seen = 1'b0;
    @(negedge clk);
    bus.req  = 1'b1;
    bus.we   = twe;
    bus.addr = taddr;
    bus.len  = tlen;
    @(posedge clk);
    #1 bus.req = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (bus.wready || bus.rvalid) begin
        if (nbeats < 16) begin
          beat_cyc[nbeats] = k;
          beat_dat[nbeats] = bus.rdata;
        end
        if (bus.wready) bus.wdata = tbase + 32'(nbeats);
        nbeats++;
      end
      if (bus.done) begin
        done_cyc = k;
        err_seen = bus.err;
        break;
      end
    end
    @(negedge clk);
    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 32'd0;
    bus.len   = 8'd0;
    bus.wdata = 32'd0;
`ifdef DISK_WRITE_PROTECT_EN
    wp        = 1'b0;
`endif

    //           we    addr       len   base        done err   beats first c2  head    data
    vecs[0]  = '{1'b1, 32'd5,    8'd3, 32'hA,     5,  1'b0, 3, 2, 4,  32'd0,  1'b0};
    vecs[1]  = '{1'b0, 32'd5,    8'd3, 32'hA,     5,  1'b0, 3, 3, 5,  32'd0,  1'b1};
    vecs[2]  = '{1'b1, 32'd62,   8'd4, 32'h1,     10, 1'b0, 4, 2, 8,  32'd1,  1'b0};
    vecs[3]  = '{1'b0, 32'd62,   8'd4, 32'h1,     14, 1'b0, 4, 7, 13, 32'd1,  1'b1};
    vecs[4]  = '{1'b0, 32'd130,  8'd1, 32'h0,     7,  1'b0, 1, 7, 0,  32'd2,  1'b0};
    vecs[5]  = '{1'b1, 32'd1020, 8'd4, 32'h100,   10, 1'b0, 4, 6, 8,  32'd15, 1'b0};
    vecs[6]  = '{1'b1, 32'd1022, 8'd4, 32'h200,   2,  1'b1, 0, 0, 0,  32'd15, 1'b0};
    vecs[7]  = '{1'b0, 32'd1022, 8'd4, 32'h0,     2,  1'b1, 0, 0, 0,  32'd15, 1'b0};
    vecs[8]  = '{1'b0, 32'd1020, 8'd4, 32'h100,   6,  1'b0, 4, 3, 5,  32'd15, 1'b1};
    vecs[9]  = '{1'b1, 32'd7,    8'd0, 32'h77,    7,  1'b0, 1, 6, 0,  32'd0,  1'b0};
    vecs[10] = '{1'b0, 32'd7,    8'd0, 32'h77,    3,  1'b0, 1, 3, 0,  32'd0,  1'b1};

    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'd0, bus.busy},   32'd0);
    chk("rst_wready", {31'd0, bus.wready}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst_done",   {31'd0, bus.done},   32'd0);
    chk("rst_err",    {31'd0, bus.err},    32'd0);
    chk("rst_rdata",  bus.rdata,           32'd0);
    chk("rst_head",   head_sector,         32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].base);
      chk($sformatf("v%0d_done_cycle", i), 32'(done_cyc), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), {31'd0, err_seen}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_beats", i), 32'(nbeats), 32'(vecs[i].exp_beats));
      if (vecs[i].exp_beats > 0 && nbeats > 0)
        chk($sformatf("v%0d_first_beat", i), 32'(beat_cyc[0]), 32'(vecs[i].exp_first));
      if (vecs[i].exp_beats > 2 && nbeats > 2)
        chk($sformatf("v%0d_beat2_cycle", i), 32'(beat_cyc[2]), 32'(vecs[i].exp_cyc2));
      if (vecs[i].chk_data) begin
        for (int j = 0; j < vecs[i].exp_beats && j < nbeats; j++)
          chk($sformatf("v%0d_rdata%0d", i, j), beat_dat[j], vecs[i].base + 32'(j));
      end
      chk($sformatf("v%0d_head", i), head_sector, vecs[i].exp_head);
    end

    // Reset in the middle of a sector-1 read burst of 8 words
    @(negedge clk);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'd64;
    bus.len  = 8'd8;
    @(posedge clk);
    #1 bus.req = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_rvalid_before_rst", {31'd0, bus.rvalid}, 32'd1);
    chk("mid_head_before_rst",   head_sector,         32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   {31'd0, bus.busy},   32'd0);
    chk("mid_rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("mid_rst_done",   {31'd0, bus.done},   32'd0);
    chk("mid_rst_head",   head_sector,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 32'd5, 8'd3, 32'h0);
    chk("post_rst_done_cycle", 32'(done_cyc), 32'd5);
    chk("post_rst_beats",      32'(nbeats),   32'd3);
    chk("post_rst_rdata0",     beat_dat[0],   32'hA);
    chk("post_rst_rdata1",     beat_dat[1],   32'hB);
    chk("post_rst_rdata2",     beat_dat[2],   32'h77);

`ifdef DISK_WRITE_PROTECT_EN
    wp = 1'b1;
    run_txn(1'b1, 32'd5, 8'd1, 32'hDEAD);
    chk("wp_done_cycle", 32'(done_cyc),       32'd2);
    chk("wp_err",        {31'd0, err_seen},   32'd1);
    chk("wp_beats",      32'(nbeats),         32'd0);
    wp = 1'b0;
    run_txn(1'b0, 32'd5, 8'd1, 32'h0);
    chk("wp_readback",   beat_dat[0],         32'hA);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
